// File: rtl/motor_pkg.sv
// motor_pkg: shared types and helpers for the motor PWM driver.
//   SPEED_W      width of speed words and of the shared period counter
//   speed_t      duty / counter word
//   chan_state_t per-channel H-bridge state (IDLE, DRIVE, DEAD)
//   clamp_speed  saturates a requested duty to the PWM period
package motor_pkg;

  localparam int SPEED_W = 21;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } chan_state_t;

  function automatic speed_t clamp_speed(input speed_t req, input speed_t limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one H-bridge channel (left or right wheel).
// Holds the shadowed duty, the direction/dead-time FSM and the registered
// bridge outputs. Inputs are only sampled on the boundary strobe, so a
// whole PWM period always runs with one duty and one direction.
//
// Optional build macro: MOTOR_RAMP_EN -- effective duty slews toward the
// clamped target by at most RAMP_STEP per period and restarts from 0 after
// a reversal or disable. Without it the clamped target applies at once.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   enable        1 = may drive; 0 = immediate coast and return to IDLE
//   boundary      high in the last counter cycle of each period
//   counter       shared period counter (0..PERIOD-1)
//   speed         requested duty in clk cycles
//   dir           requested direction, 1 = forward
//   in_a, in_b    registered bridge inputs (never both high)
//   busy          registered, high while the channel sits in DEAD
module pwm_channel
  import motor_pkg::*;
#(
  parameter int PERIOD       = 50000,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 500
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               boundary,
  input  logic [SPEED_W-1:0] counter,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  output logic               in_a,
  output logic               in_b,
  output logic               busy
);

  localparam speed_t PERIOD_W = speed_t'(PERIOD);
  localparam int     DEAD_W   = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);

  chan_state_t       state;
  logic              active_dir;
  speed_t            duty;
  logic [DEAD_W-1:0] dead_cnt;

  speed_t target;
  speed_t duty_step;   // duty to load when the channel keeps/starts driving
  speed_t duty_stop;   // duty to load when the channel leaves DRIVE
  logic   pwm;

  assign target = clamp_speed(speed, PERIOD_W);
  assign pwm    = (counter < duty);

`ifdef MOTOR_RAMP_EN
  localparam logic [SPEED_W:0] STEP = (SPEED_W + 1)'(RAMP_STEP);

  // Move cur toward tgt by at most STEP; one extra bit keeps the sums from
  // wrapping near the top of the speed range.
  function automatic speed_t ramp_toward(input speed_t cur, input speed_t tgt);
    logic [SPEED_W:0] up;
    logic [SPEED_W:0] floor_lim;
    up        = {1'b0, cur} + STEP;
    floor_lim = {1'b0, tgt} + STEP;
    if (cur < tgt)
      return (up >= {1'b0, tgt}) ? tgt : up[SPEED_W-1:0];
    else if ({1'b0, cur} > floor_lim)
      return cur - STEP[SPEED_W-1:0];
    else
      return tgt;
  endfunction

  assign duty_step = ramp_toward(duty, target);
  // A stopped channel restarts its ramp from zero.
  assign duty_stop = '0;
`else
  assign duty_step = target;
  assign duty_stop = duty;
`endif

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of state/duty/active_dir; blocking writes would let the
  // outputs pick up this cycle's state change one cycle too early.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      active_dir <= 1'b1;
      duty       <= '0;
      dead_cnt   <= '0;
      in_a       <= 1'b0;
      in_b       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Outputs are gated by state and direction, so in_a and in_b can
      // never be high together.
      in_a <= enable && (state == DRIVE) &&  active_dir && pwm;
      in_b <= enable && (state == DRIVE) && !active_dir && pwm;
      busy <= enable && (state == DEAD);

      if (!enable) begin
        state    <= IDLE;
        dead_cnt <= '0;
        duty     <= duty_stop;
      end else if (boundary) begin
        case (state)
          IDLE: begin
            // Nothing was driving, so no dead interval is needed.
            state      <= DRIVE;
            active_dir <= dir;
            duty       <= duty_step;
          end
          DRIVE: begin
            if (dir != active_dir) begin
              state    <= DEAD;
              dead_cnt <= DEAD_W'(DEAD_PERIODS);
              duty     <= duty_stop;
            end else begin
              duty <= duty_step;
            end
          end
          DEAD: begin
            // Counts whole periods; a direction flipping back meanwhile does
            // not shorten the coast. Exit takes the direction sampled now.
            if (dead_cnt <= DEAD_W'(1)) begin
              state      <= DRIVE;
              dead_cnt   <= '0;
              active_dir <= dir;
              duty       <= duty_step;
            end else begin
              dead_cnt <= dead_cnt - DEAD_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: dual H-bridge PWM stage between the line-following
// direction controller and the motor driver pins.
// Owns the shared period counter and period_start pulse and feeds both
// wheel channels with the same counter and boundary strobe.
//
// Optional build macro: MOTOR_RAMP_EN (duty slew limiting, see pwm_channel).
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 1 = drive motors, 0 = forced coast
//   left/right_motor_speed requested duty in clk cycles (clamped to PERIOD)
//   left/right_motor       direction, 1 = forward
//   left/right_in_a/in_b   registered bridge inputs
//   period_start           one-cycle pulse while the counter is 0
//   busy_reversing         {right,left}, high while that channel is in DEAD
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PERIOD       = 50000,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 500
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [SPEED_W-1:0] left_motor_speed,
  input  logic [SPEED_W-1:0] right_motor_speed,
  input  logic               left_motor,
  input  logic               right_motor,
  output logic               left_in_a,
  output logic               left_in_b,
  output logic               right_in_a,
  output logic               right_in_b,
  output logic               period_start,
  output logic [1:0]         busy_reversing
);

  localparam speed_t LAST = speed_t'(PERIOD - 1);

  speed_t counter;
  logic   boundary;

  assign boundary = (counter == LAST);

  // period_start is registered from the wrap condition so it is high in
  // exactly the cycle where the counter reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= '0;
      period_start <= 1'b0;
    end else begin
      counter      <= boundary ? '0 : counter + speed_t'(1);
      period_start <= boundary;
    end
  end

  pwm_channel #(
    .PERIOD       (PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS),
    .RAMP_STEP    (RAMP_STEP)
  ) u_left (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .boundary (boundary),
    .counter  (counter),
    .speed    (left_motor_speed),
    .dir      (left_motor),
    .in_a     (left_in_a),
    .in_b     (left_in_b),
    .busy     (busy_reversing[0])
  );

  pwm_channel #(
    .PERIOD       (PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS),
    .RAMP_STEP    (RAMP_STEP)
  ) u_right (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .boundary (boundary),
    .counter  (counter),
    .speed    (right_motor_speed),
    .dir      (right_motor),
    .in_a     (right_in_a),
    .in_b     (right_in_b),
    .busy     (busy_reversing[1])
  );

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream stage of the line-following direction controller.
- Consumes per-wheel speed words and per-wheel direction bits, and produces H-bridge drive signals (IN_A / IN_B with PWM) for the left and right motors.
- Provides period-aligned duty updates, saturation, and a dead interval on direction reversal so the bridge is never shoot-through.
- Sits between the direction controller and the motor driver pins.

Parameters:
- PERIOD, 50000, PWM period in clk cycles (1 kHz at 50 MHz); must be ≥2 and fit in 21 bits.
- DEAD_PERIODS, 2, whole PWM periods of coast (both outputs low) inserted on a direction change.
- RAMP_STEP, 500, maximum duty change per period when MOTOR_RAMP_EN is defined.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = drive motors; 0 = forced coast
- left_motor_speed  in  21  requested left duty in clk cycles
- right_motor_speed  in  21  requested right duty in clk cycles
- left_motor  in  1  left direction, 1 = forward
- right_motor  in  1  right direction, 1 = forward
- left_in_a  out  1  left bridge input A (PWM when forward)
- left_in_b  out  1  left bridge input B (PWM when reverse)
- right_in_a  out  1  right bridge input A
- right_in_b  out  1  right bridge input B
- period_start  out  1  one-cycle pulse at counter value 0
- busy_reversing  out  2  {right,left}: 1 while that channel is in DEAD

Behaviour:
- Reset (async, reset_n low):
  - all outputs 0;
  - counter, shadow duties and dead counters 0;
  - active directions forward;
  - both channels in IDLE.
- Shared period counter:
  - counts 0..PERIOD-1 and wraps;
  - period_start is registered and high during the cycle where counter == 0.
- Duty shadowing:
  - speed and direction inputs are sampled only in the cycle where counter == PERIOD-1;
  - the new value takes effect from counter == 0 of the next period;
  - mid-period input changes are ignored.
- Saturation: a sampled speed > PERIOD is clamped to PERIOD.
- PWM compare: pwm = (counter < duty).
  - duty 0 gives a constant low;
  - duty PERIOD gives a constant high;
  - all outputs are registered, so there is 1 cycle latency from counter to pin.
- Per-channel FSM (states IDLE, DRIVE, DEAD), evaluated at period boundaries:
  - IDLE → DRIVE when enable = 1 at a boundary. Active direction := sampled direction, with no dead interval leaving IDLE.
  - DRIVE → DEAD when the sampled direction ≠ the active direction.
    - Outputs go 00 from the next period start.
    - Dead counter := DEAD_PERIODS.
  - DEAD: decrement at each boundary. At 0, latch the new direction and go to DRIVE.
    - A direction that flips back during DEAD does not shorten DEAD.
    - The direction latched at exit is the one sampled at the exit boundary.
  - Any state → IDLE when enable = 0. This is immediate (next clk edge, not boundary-aligned), and outputs are 00.
- Drive mapping in DRIVE:
  - forward: in_a = pwm, in_b = 0;
  - reverse: in_a = 0, in_b = pwm.
- Invariant: in_a & in_b is never 1 on either channel, in any state.
- busy_reversing[i] = 1 exactly while channel i is in DEAD.

Optional Feature:
- MOTOR_RAMP_EN defined:
  - at each boundary the effective duty moves toward the clamped target by at most RAMP_STEP;
  - entering DEAD or IDLE resets the effective duty to 0, so a reversal restarts the ramp from 0.
- Undefined: effective duty = clamped target immediately; RAMP_STEP is unused.

Decomposition:
- Package motor_pkg:
  - SPEED_W = 21;
  - typedef enum logic [1:0] {IDLE, DRIVE, DEAD} chan_state_t;
  - typedef logic [SPEED_W-1:0] speed_t.
- Sub-module pwm_channel (instantiated twice) contains:
  - the shadow registers, clamp, optional ramp, FSM and output mapping;
  - it takes the shared counter and a boundary strobe as inputs.
- The top level owns the period counter, period_start and enable fan-out.

Test Plan:
- PERIOD=100, enable=1, left speed 30, forward → left_in_a high for 30 of each 100 cycles, left_in_b stuck 0, period_start every 100 cycles.
- Speed 150 → clamped: left_in_a constantly high; speed 0 → constantly low, no glitch.
- Speed changed 30→70 at counter 40 → current period keeps 30; the next period shows 70.
- Forward→reverse at DEAD_PERIODS=2:
  - exactly 200 cycles of 00 with busy_reversing[0]=1;
  - then left_in_b pulses at the duty;
  - the assertion in_a & in_b == 0 holds throughout.
- enable dropped mid-period, and reset_n asserted at counter 55 → all outputs 0 on the next edge or immediately; after release the counter restarts at 0 in IDLE.
- MOTOR_RAMP_EN, RAMP_STEP=10, target 0→45 → effective duty 10, 20, 30, 40, 45 on successive periods.
